// File: rtl/ras_pkg.sv
// ras_pkg: shared definitions for the return-address stack.
//   RAS_ADDR_W / RAS_DEPTH : default stored-address width and entry count
//   ras_op_t               : stack operation decoded from the push/pop pair
//   ras_ptr_w()            : width of an entry pointer for a given depth
//   ras_decode()           : push/pop -> ras_op_t
package ras_pkg;

    localparam int RAS_ADDR_W = 12;
    localparam int RAS_DEPTH  = 8;

    typedef enum logic [1:0] {
        RAS_NOP,
        RAS_PUSH,
        RAS_POP,
        RAS_REPLACE
    } ras_op_t;

    // Depth is a power of two >= 2, so the pointer is at least one bit wide
    // and wraps modulo DEPTH on its own.
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic ras_op_t ras_decode(input logic push, input logic pop);
        ras_op_t op;
        unique case ({push, pop})
            2'b10:   op = RAS_PUSH;
            2'b01:   op = RAS_POP;
            2'b11:   op = RAS_REPLACE;
            default: op = RAS_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ras_storage.sv
// ras_storage: DEPTH x ADDR_W entry array for the return-address stack.
// Contents are deliberately not reset.
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write entry index
//   wdata  : write data
//   raddr  : read entry index
//   rdata  : read data, combinational from raddr (zero-latency top-of-stack)
module ras_storage
    import ras_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH,
    parameter int PTR_W  = ras_ptr_w(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return-address stack. CALL pushes, RET pops and
// reads the target from top_addr in the same cycle.
// Optional feature macro: RAS_CHECKPOINT_EN builds the {tos,count} snapshot
// and restore path; without it ckpt_save/ckpt_restore are ignored and
// ckpt_valid is 0.
//   clk, reset          : clock (rising edge), async active-high reset
//   push, pop, push_addr: stack operations; push+pop replaces the top
//   flush               : empty the stack and clear sticky flags
//   ckpt_save/restore   : snapshot / reload pointer and count
//   top_addr            : current top entry (combinational), 0 when empty
//   count, empty, full  : occupancy
//   overflow, underflow : sticky error flags
//   ckpt_valid          : a snapshot is held
module ret_addr_stack
    import ras_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic                       flush,
    input  logic                       ckpt_save,
    input  logic                       ckpt_restore,
    output logic [ADDR_W-1:0]          top_addr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       ckpt_valid
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] TOS_RST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  tos_reg, tos_next, tos_inc, tos_dec;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;
    logic              is_empty, is_full;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [ADDR_W-1:0] mem_rdata;
    logic              restore_go;
    logic [PTR_W-1:0]  restore_tos;
    logic [CNT_W-1:0]  restore_count;
    ras_op_t           op;

    assign op       = ras_decode(push, pop);
    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == CNT_FULL);
    // Power-of-two depth: plain pointer arithmetic wraps modulo DEPTH.
    assign tos_inc  = tos_reg + PTR_W'(1);
    assign tos_dec  = tos_reg - PTR_W'(1);

    ras_storage #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (push_addr),
        .raddr (tos_reg),
        .rdata (mem_rdata)
    );

`ifdef RAS_CHECKPOINT_EN
    logic [PTR_W-1:0] snap_tos_reg;
    logic [CNT_W-1:0] snap_count_reg;
    logic             ckpt_valid_reg;

    // Snapshot captures the pre-update pointer/count of the save cycle, so a
    // push in that cycle sits above the restore point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_tos_reg   <= TOS_RST;
            snap_count_reg <= '0;
            ckpt_valid_reg <= 1'b0;
        end else if (flush) begin
            ckpt_valid_reg <= 1'b0;
        end else if (ckpt_save) begin
            snap_tos_reg   <= tos_reg;
            snap_count_reg <= count_reg;
            ckpt_valid_reg <= 1'b1;
        end
    end

    assign restore_go    = ckpt_restore & ckpt_valid_reg;
    assign restore_tos   = snap_tos_reg;
    assign restore_count = snap_count_reg;
    assign ckpt_valid    = ckpt_valid_reg;
`else
    logic unused_ckpt;
    assign unused_ckpt   = ckpt_save ^ ckpt_restore;
    assign restore_go    = 1'b0;
    assign restore_tos   = TOS_RST;
    assign restore_count = '0;
    assign ckpt_valid    = 1'b0;
`endif

    always_comb begin
        tos_next       = tos_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        mem_we         = 1'b0;
        mem_waddr      = tos_inc;
        if (flush) begin
            tos_next       = TOS_RST;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else if (restore_go) begin
            tos_next   = restore_tos;
            count_next = restore_count;
        end else begin
            unique case (op)
                RAS_PUSH: begin
                    // When full the new entry lands on the oldest one.
                    tos_next = tos_inc;
                    mem_we   = 1'b1;
                    if (is_full) overflow_next = 1'b1;
                    else         count_next    = count_reg + CNT_W'(1);
                end
                RAS_POP: begin
                    if (is_empty) begin
                        underflow_next = 1'b1;
                    end else begin
                        tos_next   = tos_dec;
                        count_next = count_reg - CNT_W'(1);
                    end
                end
                RAS_REPLACE: begin
                    mem_we = 1'b1;
                    if (is_empty) begin
                        // Nothing to pop: behaves as a plain push.
                        tos_next       = tos_inc;
                        count_next     = count_reg + CNT_W'(1);
                        underflow_next = 1'b1;
                    end else begin
                        mem_waddr = tos_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_reg       <= TOS_RST;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            tos_reg       <= tos_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign top_addr  = is_empty ? '0 : mem_rdata;
    assign count     = count_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack: directed scenarios plus randomized traffic for
// ret_addr_stack (DEPTH=4, ADDR_W=12) against a stack model kept here.
module tb_ret_addr_stack;

    localparam int AW = 12;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic          ckpt_save = 1'b0, ckpt_restore = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic [AW-1:0] top_addr;
    logic [2:0]    count;
    logic          empty, full, overflow, underflow, ckpt_valid;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: stack entries in a circular array with a top index.
    logic [AW-1:0] m_mem [D];
    int            m_tos, m_cnt, m_snap_tos, m_snap_cnt;
    bit            m_ovf, m_unf, m_cv;
    logic [AW-1:0] top_seen;

    ret_addr_stack #(.ADDR_W(AW), .DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .push_addr    (push_addr),
        .flush        (flush),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .top_addr     (top_addr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow),
        .ckpt_valid   (ckpt_valid)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_tos = D - 1; m_cnt = 0; m_ovf = 0; m_unf = 0; m_cv = 0;
        m_snap_tos = D - 1; m_snap_cnt = 0;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
    endfunction

    function automatic void model_push(input logic [AW-1:0] a);
        m_tos = (m_tos + 1) % D;
        m_mem[m_tos] = a;
        if (m_cnt == D) m_ovf = 1;
        else            m_cnt++;
    endfunction

    function automatic void model_step(input bit p, input bit po, input logic [AW-1:0] a,
                                       input bit fl, input bit sv, input bit rs);
        int  old_tos = m_tos;
        int  old_cnt = m_cnt;
        bit  do_restore = 0;
        if (fl) begin
            m_cnt = 0; m_tos = D - 1; m_ovf = 0; m_unf = 0; m_cv = 0;
            return;
        end
`ifdef RAS_CHECKPOINT_EN
        do_restore = rs && m_cv;
`endif
        if (do_restore) begin
            m_tos = m_snap_tos; m_cnt = m_snap_cnt;
        end else if (p && po) begin
            if (m_cnt > 0) m_mem[m_tos] = a;
            else begin model_push(a); m_unf = 1; end
        end else if (p) begin
            model_push(a);
        end else if (po) begin
            if (m_cnt > 0) begin m_tos = (m_tos + D - 1) % D; m_cnt--; end
            else m_unf = 1;
        end
`ifdef RAS_CHECKPOINT_EN
        if (sv) begin m_snap_tos = old_tos; m_snap_cnt = old_cnt; m_cv = 1; end
`else
        if (sv || rs || old_tos < 0) m_cv = 0;
`endif
    endfunction

    function automatic logic [AW-1:0] model_top();
        return (m_cnt == 0) ? '0 : m_mem[m_tos];
    endfunction

    // One transaction: inputs driven at negedge, top_addr sampled before the
    // edge, model advanced at the edge, back at the next negedge on return.
    task automatic cycle(input bit p, input bit po, input logic [AW-1:0] a,
                         input bit fl = 0, input bit sv = 0, input bit rs = 0);
        push = p; pop = po; push_addr = a; flush = fl;
        ckpt_save = sv; ckpt_restore = rs;
        #1 top_seen = top_addr;
        @(posedge clk);
        model_step(p, po, a, fl, sv, rs);
        @(negedge clk);
        push = 0; pop = 0; flush = 0; ckpt_save = 0; ckpt_restore = 0;
        txn++;
        $display("txn %0d: push=%0b pop=%0b addr=%03h flush=%0b save=%0b rest=%0b top_before=%03h count=%0d ovf=%0b unf=%0b cv=%0b",
                 txn, p, po, a, fl, sv, rs, top_seen, count, overflow, underflow, ckpt_valid);
    endtask

    task automatic test_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if (top_addr !== 12'h000) begin errors++; $display("FAIL reset_top got %03h want 000", top_addr); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || ckpt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ovf=%0b unf=%0b cv=%0b want 0 0 0", overflow, underflow, ckpt_valid);
        end
        cycle(0, 0, '0);
        checks++; if (count !== 3'd0 || empty !== 1'b1 || top_addr !== 12'h000) begin
            errors++; $display("FAIL idle_state got count=%0d empty=%0b top=%03h want 0 1 000", count, empty, top_addr);
        end
    endtask

    task automatic test_push_pop();
        logic [AW-1:0] want;
        cycle(1, 0, 12'h101); cycle(1, 0, 12'h102); cycle(1, 0, 12'h103);
        checks++; if (top_addr !== 12'h103 || count !== 3'd3) begin
            errors++; $display("FAIL push3 got top=%03h count=%0d want 103 3", top_addr, count);
        end
        for (int i = 0; i < 3; i++) begin
            want = 12'h103 - 12'(i);
            cycle(0, 1, '0);
            checks++; if (top_seen !== want) begin
                errors++; $display("FAIL pop_top%0d got %03h want %03h", i, top_seen, want);
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pop_empty got %0b want 1", empty); end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] want;
        for (int i = 1; i <= 5; i++) begin
            cycle(1, 0, 12'h200 + 12'(i));
            if (i == 4) begin
                checks++; if (full !== 1'b1 || overflow !== 1'b0) begin
                    errors++; $display("FAIL full4 got full=%0b ovf=%0b want 1 0", full, overflow);
                end
            end
        end
        checks++; if (overflow !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL ovf5 got ovf=%0b count=%0d want 1 4", overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            want = 12'h205 - 12'(i);
            cycle(0, 1, '0);
            checks++; if (top_seen !== want) begin
                errors++; $display("FAIL ovf_pop%0d got %03h want %03h", i, top_seen, want);
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        cycle(0, 0, '0, 1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_flush got %0b want 0", overflow); end
    endtask

    task automatic test_underflow();
        cycle(0, 1, '0);
        checks++; if (top_seen !== 12'h000 || underflow !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL unf got top=%03h unf=%0b count=%0d want 000 1 0", top_seen, underflow, count);
        end
        cycle(0, 0, '0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got %0b want 1", underflow); end
        cycle(0, 0, '0, 1);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_flush got %0b want 0", underflow); end
    endtask

    task automatic test_replace();
        cycle(1, 0, 12'h301);
        cycle(1, 1, 12'h3AA);
        checks++; if (top_seen !== 12'h301 || count !== 3'd1 || top_addr !== 12'h3AA) begin
            errors++; $display("FAIL replace got seen=%03h count=%0d top=%03h want 301 1 3aa", top_seen, count, top_addr);
        end
        // push+pop on an empty stack acts as a push and flags underflow.
        cycle(0, 0, '0, 1);
        cycle(1, 1, 12'h3BB);
        checks++; if (top_seen !== 12'h000 || count !== 3'd1 || top_addr !== 12'h3BB || underflow !== 1'b1) begin
            errors++; $display("FAIL replace_empty got seen=%03h count=%0d top=%03h unf=%0b want 000 1 3bb 1",
                               top_seen, count, top_addr, underflow);
        end
        cycle(0, 0, '0, 1);
    endtask

    task automatic test_ckpt();
        cycle(1, 0, 12'h401);
        cycle(0, 0, '0, 0, 1);
        cycle(1, 0, 12'h402);
        cycle(1, 0, 12'h403);
        cycle(0, 0, '0, 0, 0, 1);
`ifdef RAS_CHECKPOINT_EN
        checks++; if (count !== 3'd1 || top_addr !== 12'h401 || ckpt_valid !== 1'b1) begin
            errors++; $display("FAIL restore got count=%0d top=%03h cv=%0b want 1 401 1", count, top_addr, ckpt_valid);
        end
        cycle(1, 0, 12'h4CC, 0, 0, 1);
        checks++; if (count !== 3'd1 || top_addr !== 12'h401) begin
            errors++; $display("FAIL restore_drop got count=%0d top=%03h want 1 401", count, top_addr);
        end
`else
        checks++; if (count !== 3'd3 || top_addr !== 12'h403 || ckpt_valid !== 1'b0) begin
            errors++; $display("FAIL ckpt_off got count=%0d top=%03h cv=%0b want 3 403 0", count, top_addr, ckpt_valid);
        end
        cycle(1, 0, 12'h4CC, 0, 0, 1);
        checks++; if (count !== 3'd4 || top_addr !== 12'h4CC) begin
            errors++; $display("FAIL ckpt_off_push got count=%0d top=%03h want 4 4cc", count, top_addr);
        end
`endif
        cycle(0, 0, '0, 1);
        checks++; if (ckpt_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL ckpt_flush got cv=%0b count=%0d want 0 0", ckpt_valid, count);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 12'h501);
        cycle(1, 0, 12'h502);
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++; if (count !== 3'd0 || empty !== 1'b1 || top_addr !== 12'h000) begin
            errors++; $display("FAIL async_reset got count=%0d empty=%0b top=%03h want 0 1 000", count, empty, top_addr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        bit p, po, fl, sv, rs;
        logic [AW-1:0] a, exp_top;
        for (int i = 0; i < 400; i++) begin
            p  = ($urandom_range(0, 2) != 0);
            po = ($urandom_range(0, 1) != 0);
            fl = ($urandom_range(0, 40) == 0);
            sv = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 7) == 0);
            a  = AW'($urandom);
            exp_top = model_top();
            cycle(p, po, a, fl, sv, rs);
            checks++; if (top_seen !== exp_top) begin
                errors++; $display("FAIL rnd_top it=%0d got %03h want %03h", i, top_seen, exp_top);
            end
            checks++; if (count !== 3'(m_cnt) || empty !== (m_cnt == 0) || full !== (m_cnt == D)) begin
                errors++; $display("FAIL rnd_count it=%0d got %0d/%0b/%0b want %0d", i, count, empty, full, m_cnt);
            end
            checks++; if (overflow !== m_ovf || underflow !== m_unf || ckpt_valid !== m_cv) begin
                errors++; $display("FAIL rnd_flags it=%0d got %0b%0b%0b want %0b%0b%0b",
                                   i, overflow, underflow, ckpt_valid, m_ovf, m_unf, m_cv);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_ckpt();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
